clk_rst_ctrl: RTL and testbench
===============================

Name: clk_rst_ctrl

Overview:
- Parametrised clock-enable and reset controller for the board top level.
- Replaces ad-hoc counter-bit clocks and the free-running power-on reset counter.
- Provides a stretched reset with synchronous deassert, and NUM_CH programmable tick/phase channels for LEDs, UART pacing and similar loads.
- Provides a run/single-step gated clock enable for the multi-cycle RISC-V core, all in the single CLK12MHZ domain.

Parameters:
- NUM_CH, 4, number of divider channels (1..8); channel 0 paces cpu_ce_o.
- DIV_W, 24, width of each divisor and counter.
- RST_CYCLES, 16, cycles sys_rstn_o is held low after synchronised reset release (>=1).
- DIV_DEFAULT, 2**20-1, divisor loaded into every channel at reset.

Ports:
- CLK12MHZ  in  1  system clock.
- resetn  in  1  Asynchronous, active-low reset. All flops clear on its falling edge.
- div_i  in  NUM_CH*DIV_W  Divisor per channel; channel k occupies bits [k*DIV_W +: DIV_W].
- div_load_i  in  NUM_CH  Per-channel strobe that latches div_i and restarts that counter.
- run_i  in  1  1 = CPU free-runs at the channel-0 tick rate; 0 = halted, single-step only.
- step_i  in  1  Level input; a rising edge requests one CPU step while halted.
- rst_req_i  in  1  Synchronous soft-reset request; restarts the reset sequence.
- sys_rstn_o  out  1  Active-low system reset; asynchronous assert, synchronous deassert.
- rst_busy_o  out  1  High while the reset FSM is not in RUN.
- tick_o  out  NUM_CH  One-cycle pulse per channel period.
- phase_o  out  NUM_CH  Toggles on each tick; square wave with period 2*(div+1).
- cpu_ce_o  out  1  One-cycle CPU clock enable.

Behaviour:
- Reset values, forced asynchronously while resetn=0:
  - sys_rstn_o=0, rst_busy_o=1.
  - tick_o=0, phase_o=0, cpu_ce_o=0.
  - All counters=0; divisors=DIV_DEFAULT; step pending=0; FSM=SYNC.
- Reset FSM:
  - SYNC: a 2-flop synchroniser samples the released resetn. After 2 edges, go to HOLD with hold counter=0.
  - HOLD: the hold counter increments each cycle. When it reaches RST_CYCLES-1, go to RUN.
  - RUN: sys_rstn_o=1 and rst_busy_o=0, both registered.
  - rst_req_i=1 in any state: next state is HOLD with counter=0, and sys_rstn_o=0 from the next edge.
- Reset latency: sys_rstn_o rises on edge 2+RST_CYCLES after resetn is released.
- While sys_rstn_o=0, channel counters, phase_o, tick_o, cpu_ce_o and the step flag are held at 0. Divisor registers keep their values across a soft reset.
- Channel k (only while in RUN):
  - If div_load_i[k]=1: div<=div_i slice, cnt<=0, tick_o[k]<=0. Load wins over a simultaneous wrap, and no tick is emitted.
  - Else if cnt==div: cnt<=0, tick_o[k]<=1, phase_o[k]<=~phase_o[k].
  - Else: cnt<=cnt+1, tick_o[k]<=0.
  - Outcome: with divisor D, ticks occur every D+1 cycles. D=0 gives tick_o constantly 1 and phase_o toggling every cycle.
  - The first tick is registered on edge D+1 after sys_rstn_o rises, or after the load edge.
  - Counter width is DIV_W and never exceeds div, so there is no overflow wrap.
- CPU enable:
  - step_i passes through a 2-flop synchroniser plus edge detect.
  - run_i=1: cpu_ce_o<=tick_o[0] source, i.e. it is the same-cycle registered tick. The pending flag is cleared.
  - run_i=0: a step edge sets pending. On the next channel-0 wrap, cpu_ce_o pulses once and pending clears.
  - Step edges while pending is already set are dropped (not queued).
  - A step edge and a channel-0 wrap in the same cycle: the step is served on the following wrap.
  - cpu_ce_o is never high for two consecutive cycles unless channel-0 D=0 and run_i=1.

Decomposition:
- Package clk_rst_pkg:
  - Reset FSM state encoding (SYNC=2'd0, HOLD=2'd1, RUN=2'd2).
  - Synchroniser depth constant (2).
  - Default-divisor constant.
- Sub-module tick_div (parameter DIV_W):
  - Inputs: CLK12MHZ, resetn, en, load, div.
  - Outputs: tick, phase.
  - Instantiated NUM_CH times in a generate loop.
- The reset FSM, synchronisers and step logic stay in clk_rst_ctrl.

Test Plan:
- Power-on reset: RST_CYCLES=16, resetn low 5 cycles then high -> sys_rstn_o rises on edge 18 after release; tick_o, phase_o and cpu_ce_o stay 0 until then.
- Mid-run async reset: drop resetn asynchronously mid-period -> all outputs reach reset values without a clock edge; divisors return to DIV_DEFAULT.
- Divisor load: load div=3 on ch1 -> tick_o[1] high on edges 4, 8, 12 after the load; phase_o[1] period 8. Load div=0 -> tick_o[1] constantly 1.
- Load/wrap collision: div_load_i[2]=1 on the cycle cnt==div -> no tick that cycle; next tick D'+1 cycles later.
- Single-step: ch0 div=9, run_i=0, step_i rises three times spaced 30 cycles -> exactly three cpu_ce_o pulses, each coincident with a channel-0 wrap. Two step edges within one period -> one pulse.
- Soft reset: pulse rst_req_i during RUN -> sys_rstn_o low next edge for 16 cycles, rst_busy_o=1, counters cleared; divisor values retained (ch1 still div=3).

Source files
------------

// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared reset-FSM encoding and constants for the clock/reset controller
package clk_rst_pkg;
  typedef enum logic [1:0] {SYNC = 2'd0, HOLD = 2'd1, RUN = 2'd2} rst_state_e;
  localparam int SYNC_DEPTH    = 2;
  localparam int DIV_DEFAULT_C = 2**20 - 1;
endpackage

// File: rtl/tick_div.sv
// tick_div: programmable divider producing a one-cycle tick every div+1 cycles and a toggling phase
// Ports: CLK12MHZ clock; resetn async active-low reset; en counts only while high (else clears);
//        load latches div and restarts; tick/phase registered outputs; wrap is next-cycle tick.
module tick_div import clk_rst_pkg::*; #(
  parameter int               DIV_W   = 24,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT_C)
) (
  input  logic             CLK12MHZ,
  input  logic             resetn,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             phase,
  output logic             wrap
);
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic             tick_q, phase_q, phase_d;
  // a load in the wrap cycle suppresses that tick
  assign wrap = en & ~load & (cnt_q == div_q);
  always_comb begin
    div_d   = (en & load) ? div : div_q;
    cnt_d   = (en & ~load & ~wrap) ? cnt_q + 1'b1 : '0;
    phase_d = en & (phase_q ^ wrap);
  end
  always_ff @(posedge CLK12MHZ or negedge resetn)
    if (!resetn) begin
      div_q   <= DIV_RST;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tick_q  <= wrap;
      phase_q <= phase_d;
    end
  assign tick  = tick_q;
  assign phase = phase_q;
endmodule

// File: rtl/clk_rst_ctrl.sv
// clk_rst_ctrl: stretched system reset, NUM_CH tick/phase dividers and run/step CPU clock enable
// Ports: CLK12MHZ clock; resetn async active-low reset; div_i/div_load_i per-channel divisor load;
//        run_i free-run vs halted; step_i single-step level; rst_req_i soft reset;
//        sys_rstn_o/rst_busy_o reset status; tick_o/phase_o channel outputs; cpu_ce_o CPU enable.
module clk_rst_ctrl import clk_rst_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 24,
  parameter int RST_CYCLES  = 16,
  parameter int DIV_DEFAULT = DIV_DEFAULT_C
) (
  input  logic                    CLK12MHZ,
  input  logic                    resetn,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       div_load_i,
  input  logic                    run_i,
  input  logic                    step_i,
  input  logic                    rst_req_i,
  output logic                    sys_rstn_o,
  output logic                    rst_busy_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       phase_o,
  output logic                    cpu_ce_o
);
  localparam int                HOLD_W    = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  rst_state_e              state_q;
  logic [HOLD_W-1:0]       hold_q;
  logic [SYNC_DEPTH-1:0]   sync_q;
  logic                    sys_rstn_q, busy_q;
  logic [2:0]              step_q;
  logic                    step_edge, pend_q, pend_d, ce_q, ce_d;
  logic [NUM_CH-1:0]       wrap;
  logic                    unused_wrap;
  // SYNC leaves on the edge that loads the last synchroniser stage, giving release-to-RUN of 2+RST_CYCLES edges
  always_ff @(posedge CLK12MHZ or negedge resetn)
    if (!resetn) begin
      state_q    <= SYNC;
      hold_q     <= '0;
      sync_q     <= '0;
      sys_rstn_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
      if (rst_req_i) begin
        state_q    <= HOLD;
        hold_q     <= '0;
        sys_rstn_q <= 1'b0;
        busy_q     <= 1'b1;
      end else case (state_q)
        SYNC: if (sync_q[SYNC_DEPTH-2]) begin
          state_q <= HOLD;
          hold_q  <= '0;
        end
        HOLD: if (hold_q == HOLD_LAST) begin
          state_q    <= RUN;
          sys_rstn_q <= 1'b1;
          busy_q     <= 1'b0;
        end else hold_q <= hold_q + 1'b1;
        default: ;
      endcase
    end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tick_div #(.DIV_W(DIV_W), .DIV_RST(DIV_W'(DIV_DEFAULT))) u_div (
      .CLK12MHZ (CLK12MHZ),
      .resetn   (resetn),
      .en       (sys_rstn_q),
      .load     (div_load_i[k]),
      .div      (div_i[k*DIV_W +: DIV_W]),
      .tick     (tick_o[k]),
      .phase    (phase_o[k]),
      .wrap     (wrap[k])
    );
  end
  assign unused_wrap = ^wrap;
  // cpu_ce_q shares its next value with channel 0's tick, so it lines up with tick_o[0]
  assign step_edge = step_q[1] & ~step_q[2];
  always_comb begin
    ce_d   = wrap[0] & (run_i | pend_q);
    pend_d = sys_rstn_q & ~run_i & (pend_q ? ~wrap[0] : step_edge);
  end
  always_ff @(posedge CLK12MHZ or negedge resetn)
    if (!resetn) begin
      step_q <= '0;
      pend_q <= 1'b0;
      ce_q   <= 1'b0;
    end else begin
      step_q <= {step_q[1:0], step_i};
      pend_q <= pend_d;
      ce_q   <= ce_d;
    end
  assign sys_rstn_o = sys_rstn_q;
  assign rst_busy_o = busy_q;
  assign cpu_ce_o   = ce_q;
endmodule

// File: tb/tb_clk_rst_ctrl.sv
// tb_clk_rst_ctrl: scoreboard bench for clk_rst_ctrl (expected pulse edges queued, matched by a monitor)
module tb_clk_rst_ctrl;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 24;
  logic clk = 1'b0, resetn = 1'b0, run_i = 1'b0, step_i = 1'b0, rst_req_i = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_i = '0;
  logic [NUM_CH-1:0]       div_load_i = '0;
  logic                    sys_rstn_o, rst_busy_o, cpu_ce_o;
  logic [NUM_CH-1:0]       tick_o, phase_o;
  int    n_tests = 0, n_fail = 0, cyc = 0, watch = -1;
  int    exp_q[$];
  string tag = "";
  int    c0, L, L0, C, E, S, W0;

  clk_rst_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYCLES(16)) dut (
    .CLK12MHZ   (clk),
    .resetn     (resetn),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .run_i      (run_i),
    .step_i     (step_i),
    .rst_req_i  (rst_req_i),
    .sys_rstn_o (sys_rstn_o),
    .rst_busy_o (rst_busy_o),
    .tick_o     (tick_o),
    .phase_o    (phase_o),
    .cpu_ce_o   (cpu_ce_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", t, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_load(input int ch, input logic [DIV_W-1:0] v);
    div_i[ch*DIV_W +: DIV_W] = v;
    div_load_i[ch] = 1'b1;
    @(negedge clk);
    div_load_i = '0;
  endtask

  task automatic step_pulse(input int at, input int len);
    wait_cyc(at);
    step_i = 1'b1;
    wait_cyc(at + len);
    step_i = 1'b0;
  endtask

  // first channel-0 wrap edge that can serve a step raised at negedge s (sync + edge detect take 3 edges)
  function automatic int next_wrap(input int first, input int s);
    int w = first;
    while (w < s + 4) w += 10;
    return w;
  endfunction

  always @(negedge clk)
    if (watch >= 0 && (watch < NUM_CH ? tick_o[watch] : cpu_ce_o)) begin
      if (exp_q.size() == 0) chk({tag, "_extra"}, cyc, 0);
      else chk(tag, cyc, exp_q.pop_front());
      if (watch == NUM_CH) chk("ce_on_wrap", tick_o[0], 1);
    end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("por_rstn", sys_rstn_o, 0);
    chk("por_busy", rst_busy_o, 1);
    chk("por_tick", tick_o, 0);
    chk("por_phase", phase_o, 0);
    chk("por_ce", cpu_ce_o, 0);
    resetn = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 17);
    chk("rel17_rstn", sys_rstn_o, 0);
    chk("rel17_busy", rst_busy_o, 1);
    chk("rel17_tick", tick_o, 0);
    chk("rel17_ce", cpu_ce_o, 0);
    wait_cyc(c0 + 18);
    chk("rel18_rstn", sys_rstn_o, 1);
    chk("rel18_busy", rst_busy_o, 0);

    L = cyc + 1;
    tag = "ch1_d3";
    exp_q = {L + 4, L + 8, L + 12};
    watch = 1;
    do_load(1, 3);
    wait_cyc(L + 5);
    chk("ch1_ph_hi", phase_o[1], 1);
    wait_cyc(L + 9);
    chk("ch1_ph_lo", phase_o[1], 0);
    wait_cyc(L + 14);
    watch = -1;
    chk("ch1_d3_left", exp_q.size(), 0);

    L = cyc + 1;
    do_load(1, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_cyc(L + i);
      chk("ch1_d0_tick", tick_o[1], 1);
      chk("ch1_d0_phase", phase_o[1], 1 ^ (i & 1));
    end
    do_load(1, 3);

    L = cyc + 1;
    do_load(2, 4);
    C = L + 5;
    wait_cyc(C - 1);
    tag = "ch2_col";
    exp_q = {C + 3, C + 6};
    watch = 2;
    do_load(2, 2);
    chk("col_phase", phase_o[2], 0);
    wait_cyc(C + 7);
    watch = -1;
    chk("ch2_col_left", exp_q.size(), 0);

    L0 = cyc + 1;
    do_load(0, 9);
    tag = "step";
    exp_q = {next_wrap(L0 + 10, L0 + 7), next_wrap(L0 + 10, L0 + 37), next_wrap(L0 + 10, L0 + 72)};
    watch = NUM_CH;
    step_pulse(L0 + 7, 3);
    step_pulse(L0 + 37, 3);
    step_pulse(L0 + 72, 3);
    wait_cyc(L0 + 95);
    watch = -1;
    chk("step_left", exp_q.size(), 0);
    W0 = L0 + 100;
    tag = "dbl";
    exp_q = {W0 + 10};
    watch = NUM_CH;
    step_pulse(W0 + 1, 2);
    step_pulse(W0 + 6, 2);
    wait_cyc(W0 + 35);
    watch = -1;
    chk("dbl_left", exp_q.size(), 0);
    wait_cyc(L0 + 145);
    tag = "run";
    exp_q = {L0 + 150, L0 + 160};
    watch = NUM_CH;
    run_i = 1'b1;
    wait_cyc(L0 + 165);
    run_i = 1'b0;
    wait_cyc(L0 + 175);
    watch = -1;
    chk("run_left", exp_q.size(), 0);

    rst_req_i = 1'b1;
    @(negedge clk);
    rst_req_i = 1'b0;
    E = cyc;
    S = E + 16;
    chk("soft_rstn", sys_rstn_o, 0);
    chk("soft_busy", rst_busy_o, 1);
    wait_cyc(E + 2);
    chk("soft_tick", tick_o, 0);
    chk("soft_phase", phase_o, 0);
    chk("soft_ce", cpu_ce_o, 0);
    wait_cyc(E + 15);
    chk("soft15_rstn", sys_rstn_o, 0);
    wait_cyc(S);
    chk("soft16_rstn", sys_rstn_o, 1);
    chk("soft16_busy", rst_busy_o, 0);
    tag = "soft_ch1";
    exp_q = {S + 4, S + 8, S + 12};
    watch = 1;
    wait_cyc(S + 10);
    chk("soft_ch0_keep", tick_o[0], 1);
    wait_cyc(S + 14);
    watch = -1;
    chk("soft_ch1_left", exp_q.size(), 0);

    L = cyc + 1;
    do_load(1, 0);
    wait_cyc(L + 2);
    chk("pre_async_tick1", tick_o[1], 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rstn", sys_rstn_o, 0);
    chk("async_busy", rst_busy_o, 1);
    chk("async_tick", tick_o, 0);
    chk("async_phase", phase_o, 0);
    chk("async_ce", cpu_ce_o, 0);
    @(negedge clk);
    resetn = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 18);
    chk("async_rel_rstn", sys_rstn_o, 1);
    wait_cyc(c0 + 23);
    chk("div_default_t1", tick_o, 0);
    wait_cyc(c0 + 30);
    chk("div_default_t2", tick_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
